// File: rtl/and_pulse_monitor.sv
// Pulse monitor for the asynchronous and_gate output: two-flop synchronizer, edge
// detection, pulse counting, pulse-width measurement and glitch flagging.
module and_pulse_monitor #(
    parameter int CNT_W     = 8,
    parameter int WID_W     = 8,
    parameter int MIN_WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_sig,
    input  logic             clr,
    output logic             rise,
    output logic             fall,
    output logic             busy,
    output logic [CNT_W-1:0] count,
    output logic [WID_W-1:0] last_width,
    output logic             width_valid,
    output logic             glitch,
    output logic             glitch_seen
);

    typedef enum logic {
        IDLE = 1'b0,
        HIGH = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [WID_W-1:0] WID_MAX = '1;
    localparam logic [WID_W-1:0] MIN_W   = WID_W'(MIN_WIDTH);

    state_t           state;
    logic             s1;
    logic             s2;
    logic [WID_W-1:0] width_cnt;

    // NOTE: every register here is updated with <= so all flops sample the
    // pre-edge values together; blocking assignments would chain s1 into s2
    // in a single cycle and collapse the synchronizer.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1          <= 1'b0;
            s2          <= 1'b0;
            state       <= IDLE;
            width_cnt   <= '0;
            rise        <= 1'b0;
            fall        <= 1'b0;
            busy        <= 1'b0;
            count       <= '0;
            last_width  <= '0;
            width_valid <= 1'b0;
            glitch      <= 1'b0;
            glitch_seen <= 1'b0;
        end else begin
            s1          <= in_sig;
            s2          <= s1;
            rise        <= 1'b0;
            fall        <= 1'b0;
            width_valid <= 1'b0;
            glitch      <= 1'b0;

            // Clear first; an edge in the same cycle overrides with fresh values.
            if (clr) begin
                count       <= '0;
                last_width  <= '0;
                glitch_seen <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (s2) begin
                        state     <= HIGH;
                        busy      <= 1'b1;
                        width_cnt <= WID_W'(1);
                        rise      <= 1'b1;
                        if (clr) begin
                            count <= CNT_W'(1);
                        end else if (count != CNT_MAX) begin
                            count <= count + CNT_W'(1);
                        end
                    end
                end
                HIGH: begin
                    if (s2) begin
                        if (width_cnt != WID_MAX) begin
                            width_cnt <= width_cnt + WID_W'(1);
                        end
                    end else begin
                        state       <= IDLE;
                        busy        <= 1'b0;
                        fall        <= 1'b1;
                        width_valid <= 1'b1;
                        last_width  <= width_cnt;
                        if (width_cnt < MIN_W) begin
                            glitch      <= 1'b1;
                            glitch_seen <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_and_pulse_monitor.sv
// Scoreboard bench for and_pulse_monitor: a level/run-length model predicts edge
// events and per-cycle statistics; a monitor compares them against the DUT.
module tb_and_pulse_monitor;

    localparam int CNT_W     = 8;
    localparam int WID_W     = 8;
    localparam int MIN_WIDTH = 3;
    localparam int CNT_SAT   = (1 << CNT_W) - 1;
    localparam int WID_SAT   = (1 << WID_W) - 1;
    localparam int MAXE      = 16384;

    logic             clk;
    logic             rst;
    logic             in_sig;
    logic             clr;
    logic             rise;
    logic             fall;
    logic             busy;
    logic [CNT_W-1:0] count;
    logic [WID_W-1:0] last_width;
    logic             width_valid;
    logic             glitch;
    logic             glitch_seen;

    and_pulse_monitor #(
        .CNT_W    (CNT_W),
        .WID_W    (WID_W),
        .MIN_WIDTH(MIN_WIDTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_sig     (in_sig),
        .clr        (clr),
        .rise       (rise),
        .fall       (fall),
        .busy       (busy),
        .count      (count),
        .last_width (last_width),
        .width_valid(width_valid),
        .glitch     (glitch),
        .glitch_seen(glitch_seen)
    );

    typedef struct {
        int edge_no;
        bit is_rise;
        bit glitch;
    } ev_t;

    ev_t sb[$];
    int  checks = 0;
    int  failures = 0;

    bit  smp_in   [MAXE];
    bit  smp_rst  [MAXE];
    bit  exp_busy [MAXE];
    int  exp_count[MAXE];
    int  exp_lw   [MAXE];
    bit  exp_gs   [MAXE];

    int  m_run = 0;
    int  m_count = 0;
    int  m_lw = 0;
    bit  m_gs = 1'b0;
    int  next_edge = 1;
    int  mon_edge = 0;
    int  rises_seen = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s @edge %0d: got %0d expected %0d", name, mon_edge, act, exp);
        end
    endtask

    // Reference: the level the detector reacts to at edge e is in_sig as sampled
    // two edges earlier, forced low if either of the two edges in between was reset.
    task automatic model_edge(input int e, input bit v, input bit c, input bit r);
        bit lvl;
        ev_t ev;
        smp_in[e]  = v;
        smp_rst[e] = r;
        if (r) begin
            m_run = 0; m_count = 0; m_lw = 0; m_gs = 1'b0;
        end else begin
            lvl = (e >= 3 && !smp_rst[e-1] && !smp_rst[e-2]) ? smp_in[e-2] : 1'b0;
            if (c) begin
                m_count = 0; m_lw = 0; m_gs = 1'b0;
            end
            if (lvl && m_run == 0) begin
                m_run = 1;
                if (m_count < CNT_SAT) m_count++;
                ev.edge_no = e; ev.is_rise = 1'b1; ev.glitch = 1'b0;
                sb.push_back(ev);
            end else if (lvl) begin
                if (m_run < WID_SAT) m_run++;
            end else if (m_run > 0) begin
                m_lw = m_run;
                ev.edge_no = e; ev.is_rise = 1'b0; ev.glitch = (m_run < MIN_WIDTH);
                if (ev.glitch) m_gs = 1'b1;
                sb.push_back(ev);
                m_run = 0;
            end
        end
        exp_busy[e]  = (m_run > 0);
        exp_count[e] = m_count;
        exp_lw[e]    = m_lw;
        exp_gs[e]    = m_gs;
    endtask

    task automatic step(input bit v, input bit c, input bit r);
        @(negedge clk);
        in_sig = v;
        clr    = c;
        rst    = r;
        model_edge(next_edge, v, c, r);
        next_edge++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
    endtask

    // High for w samples then low for gap samples; clr on relative step clr_at.
    task automatic pulse(input int w, input int gap, input int clr_at);
        for (int i = 0; i < w + gap; i++) step(i < w, i == clr_at, 1'b0);
    endtask

    // Monitor: per-cycle statistics from the arrays, edge pulses from the queue.
    initial begin
        ev_t ev;
        bit  any;
        forever begin
            @(posedge clk);
            #1;
            mon_edge++;
            check("busy", int'(busy), int'(exp_busy[mon_edge]));
            check("count", int'(count), exp_count[mon_edge]);
            check("last_width", int'(last_width), exp_lw[mon_edge]);
            check("glitch_seen", int'(glitch_seen), int'(exp_gs[mon_edge]));
            if (rise) rises_seen++;
            any = rise | fall | width_valid | glitch;
            if (any) begin
                if (sb.size() == 0) begin
                    check("unexpected_pulse", 1, 0);
                end else begin
                    ev = sb.pop_front();
                    check("event_edge", mon_edge, ev.edge_no);
                    check("rise", int'(rise), int'(ev.is_rise));
                    check("fall", int'(fall), int'(!ev.is_rise));
                    check("width_valid", int'(width_valid), int'(!ev.is_rise));
                    check("glitch", int'(glitch), int'(ev.glitch));
                end
            end else if (sb.size() != 0 && sb[0].edge_no <= mon_edge) begin
                ev = sb.pop_front();
                check("missed_event_edge", mon_edge + 1, ev.edge_no);
            end
        end
    end

    initial begin
        int base;
        int w;
        int g;
        rst = 1'b1;
        in_sig = 1'b0;
        clr = 1'b0;
        model_edge(1, 1'b0, 1'b0, 1'b1);
        next_edge = 2;

        // Reset with input low, then a 5-cycle pulse.
        step(1'b0, 1'b0, 1'b1);
        idle(4);
        pulse(5, 6, -1);

        // Glitch widths 1 and 2, clean width 3, then a lone clr.
        pulse(1, 4, -1);
        pulse(2, 4, -1);
        pulse(3, 4, -1);
        step(1'b0, 1'b1, 1'b0);
        idle(3);

        // Count saturation: 300 width-2 pulses, then width saturation.
        base = rises_seen;
        for (int i = 0; i < 300; i++) pulse(2, 2, -1);
        idle(4);
        check("rise_count_300", rises_seen - base, 300);
        pulse(300, 6, -1);

        // clr coinciding with a rise (after a glitch set the sticky flag).
        pulse(1, 4, -1);
        pulse(6, 5, 2);
        // clr alone while a pulse is being measured.
        pulse(8, 5, 5);

        // Reset mid-pulse with in_sig held high through and after reset.
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 1'b0);
        idle(5);

        // Randomized runs with occasional clr and rare reset.
        for (int i = 0; i < 250; i++) begin
            w = int'($urandom_range(1, 6));
            g = int'($urandom_range(1, 4));
            for (int j = 0; j < w + g; j++)
                step(j < w, $urandom_range(0, 19) == 0, $urandom_range(0, 149) == 0);
        end
        idle(6);

        check("scoreboard_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
